excess3_to_bcd_packer: RTL and testbench
========================================

# excess3_to_bcd_packer

Sequential decoder for the Excess-3 digit streams our BCD→Excess-3 converter produces. It accepts one 4-bit Excess-3 digit per handshake, most significant digit first, and subtracts the offset of 3 from each digit. It packs the results into a right-aligned multi-digit BCD word and flags any illegal code. It sits at the receiving end of an Excess-3 link and presents one completed number at a time to downstream logic through a valid/ready handshake.

## Interface
- NDIGITS, 4: maximum number of digits per frame (≥1).
- CW, $clog2(NDIGITS+1): width of the digit-count output (derived; do not override).

- clk  in  1  sole clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_digit/in_last are valid.
- in_ready  out  1  block can accept a digit.
- in_digit  in  4  Excess-3 code; bit 3 is the MSB (w), bit 0 the LSB (z).
- in_last  in  1  the current digit closes the frame.
- out_valid  out  1  a packed frame is available.
- out_ready  in  1  downstream accepts the frame.
- out_bcd  out  4*NDIGITS  packed BCD; the last digit received is in bits [3:0].
- out_count  out  CW  number of digits in the frame (1..NDIGITS).
- out_err  out  1  at least one digit in the frame was illegal.

## Operation
- The FSM has two states: COLLECT (the reset state) and HOLD.
- COLLECT: in_ready=1, out_valid=0. Each digit is accepted when in_valid && in_ready.
- Digit decode:
  - A legal code (3..12) maps to in_digit−3, truncated to 4 bits.
  - An illegal code (0..2 or 13..15) stores 4'hF and sets the sticky err flag.
- On accept, the accumulator shifts: acc <= {acc[4*NDIGITS-5:0], digit}, and count increments.
- The frame closes when the accepted digit has in_last=1, or when count reaches NDIGITS. The FSM then moves to HOLD.
- Right alignment: a frame with fewer than NDIGITS digits has zero-filled upper nibbles.
- HOLD: out_valid=1, in_ready=0. out_bcd, out_count and out_err are stable.
- When out_valid && out_ready in HOLD:
  - acc, count and err clear to 0.
  - The FSM returns to COLLECT.
- A frame that hits NDIGITS without in_last closes anyway. The next accepted digit starts a new frame.
- in_last on the NDIGITS-th digit behaves identically to a frame closed by the count limit.
- While in_ready=0, in_valid/in_digit/in_last are ignored, and upstream must hold them stable.

## Timing
- Reset values:
  - out_valid=0, in_ready=1, out_bcd=0, out_count=0, out_err=0.
  - State=COLLECT.
- out_bcd, out_count and out_err are register outputs. in_ready and out_valid are decoded only from the state register, with no combinational path from any input.
- Latency: out_valid rises on the clock edge that accepts the closing digit, and is visible the following cycle.
- Throughput: one digit per cycle inside a frame. There is one dead input cycle per frame: the HOLD cycle in which out_ready is sampled high.
- Back-to-back frames need at least N+1 cycles for N digits.
- Reset asserted mid-frame or in HOLD:
  - All registers return to reset values immediately (asynchronously).
  - The partial frame is discarded and no frame is emitted.

## Structure
- Package e3_pkg holds:
  - E3_OFFSET=4'd3, E3_MIN=4'd3, E3_MAX=4'd12.
  - E3_BAD_DIGIT=4'hF.
  - State enum {COLLECT, HOLD}.
- Sub-module excess3_digit_decode is purely combinational: 4-bit code in; 4-bit BCD plus a legal flag out. It is the exact inverse of the existing BCD→Excess-3 converter and is reused wherever single digits need decoding.
- The top level contains the FSM, the shift accumulator, the counter and the sticky error flag.

## Test plan
- Reset: hold rst for 3 cycles → out_valid=0, in_ready=1, out_bcd=0, out_count=0, out_err=0.
- Full frame: digits 0x4, 0x8, 0xC, 0x3 with in_last on the 4th, out_ready=1 → out_bcd=0x1590, out_count=4, out_err=0. out_valid is high for exactly 1 cycle, the cycle after the 4th accept.
- Short frame: 0x6, then 0xA with in_last → out_bcd=0x0037, out_count=2, out_err=0.
- Illegal code: 0x4, 0x2, 0x5 with in_last → out_bcd=0x01F2, out_count=3, out_err=1. The next frame (0x3 with in_last) → out_bcd=0x0000, out_err=0.
- Backpressure: after the 0x1590 frame, hold out_ready=0 for 5 cycles while in_valid=1 with in_digit=0x7 → in_ready=0 and the outputs are frozen. Then raise out_ready → the next cycle in_ready=1 and 0x7 is accepted into the new frame.
- Overflow without last: five digits 0x3, 0x4, 0x5, 0x6, 0x7 with no in_last → the first frame is 0x0123 with count 4. The 5th digit is accepted after the handshake. Asserting rst before any further input clears the partial frame; no out_valid appears.

Source files
------------

// File: rtl/e3_pkg.sv
// Shared constants, state type and legality helper for the Excess-3 decode path.
//   E3_OFFSET     : bias removed from every Excess-3 code
//   E3_MIN/E3_MAX : inclusive range of legal Excess-3 codes
//   E3_BAD_DIGIT  : nibble stored in place of an illegal code
package e3_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [3:0] E3_OFFSET    = 4'd3;
    localparam logic [3:0] E3_MIN       = 4'd3;
    localparam logic [3:0] E3_MAX       = 4'd12;
    localparam logic [3:0] E3_BAD_DIGIT = 4'hF;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    // True when the code lies in the legal Excess-3 window.
    function automatic logic e3_is_legal(input logic [3:0] code);
        return (code >= E3_MIN) && (code <= E3_MAX);
    endfunction

endpackage

// File: rtl/excess3_digit_decode.sv
// Combinational single-digit Excess-3 to BCD decoder; exact inverse of the
// BCD to Excess-3 converter. Illegal codes decode to E3_BAD_DIGIT.
//   code    : Excess-3 input code (bit 3 = w, bit 0 = z)
//   bcd_c   : decoded BCD digit, or E3_BAD_DIGIT when illegal
//   legal_c : code was in the legal range
module excess3_digit_decode
    import e3_pkg::*;
(
    input  logic [3:0] code,
    output logic [3:0] bcd_c,
    output logic       legal_c
);

    always_comb begin
        legal_c = e3_is_legal(code);
        bcd_c   = legal_c ? 4'(code - E3_OFFSET) : E3_BAD_DIGIT;
    end

endmodule

// File: rtl/excess3_to_bcd_packer.sv
// Collects Excess-3 digits (MSD first), decodes each to BCD and packs them
// right-aligned into one word, presented downstream over valid/ready.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : digit handshake
//   in_digit, in_last   : Excess-3 code and end-of-frame marker
//   out_valid/out_ready : frame handshake
//   out_bcd             : packed BCD, last received digit in [3:0]
//   out_count           : digits in the frame
//   out_err             : some digit in the frame was illegal
module excess3_to_bcd_packer
    import e3_pkg::*;
#(
    parameter  int unsigned NDIGITS = 4,
    localparam int unsigned CW      = $clog2(NDIGITS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_digit,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NDIGITS-1:0]   out_bcd,
    output logic [CW-1:0]          out_count,
    output logic                   out_err
);

    localparam int unsigned ACC_W    = DIGIT_W * NDIGITS;
    localparam logic [CW-1:0] LAST_IDX = CW'(NDIGITS - 1);

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CW-1:0]      count;
    logic               err;

    logic [3:0]         dec_bcd;
    logic               dec_legal;

    excess3_digit_decode u_decode (
        .code    (in_digit),
        .bcd_c   (dec_bcd),
        .legal_c (dec_legal)
    );

    // FSM, shift accumulator, digit counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
            acc   <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_valid) begin
                        // Oldest nibble falls off the top; only reachable
                        // after a clear, so nothing live is lost.
                        acc   <= ACC_W'({acc, dec_bcd});
                        count <= count + CW'(1);
                        if (!dec_legal) begin
                            err <= 1'b1;
                        end
                        if (in_last || (count == LAST_IDX)) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        acc   <= '0;
                        count <= '0;
                        err   <= 1'b0;
                        state <= COLLECT;
                    end
                end
            endcase
        end
    end

    // Handshake flags come straight from the state register.
    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == HOLD);
    assign out_bcd   = acc;
    assign out_count = count;
    assign out_err   = err;

endmodule

// File: tb/tb_excess3_to_bcd_packer.sv
// Self-checking bench for excess3_to_bcd_packer: directed scenarios plus
// randomized frames checked against an arithmetic reference model.
module tb_excess3_to_bcd_packer;

    localparam int unsigned NDIGITS = 4;
    localparam int unsigned CW      = $clog2(NDIGITS + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [3:0]           in_digit = 4'h0;
    logic                 in_last = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [4*NDIGITS-1:0] out_bcd;
    logic [CW-1:0]        out_count;
    logic                 out_err;

    int total = 0;
    int bad   = 0;

    excess3_to_bcd_packer #(.NDIGITS(NDIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digit  (in_digit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_count (out_count),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference: Excess-3 digit value, or 15 when outside 3..12.
    function automatic int ref_digit(input int code);
        if (code >= 3 && code <= 12) return code - 3;
        return 15;
    endfunction

    // Drive one digit (called just after a negedge); returns after the accept
    // edge, at the following negedge. ok=0 if never accepted.
    task automatic send(input logic [3:0] code, input logic last, output bit ok);
        bit rdy;
        ok = 1'b0;
        in_valid = 1'b1;
        in_digit = code;
        in_last  = last;
        for (int i = 0; i < 50; i++) begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait (at negedges) for out_valid, bounded.
    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    // Complete the output handshake from a negedge in HOLD.
    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({out_valid, in_ready, out_bcd, out_count, out_err} !==
            {1'b0, 1'b1, 16'h0000, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset: valid=%b ready=%b bcd=%h cnt=%0d err=%b, want 0 1 0000 0 0",
                     out_valid, in_ready, out_bcd, out_count, out_err);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_frame();
        bit ok, all_ok;
        logic [3:0] codes [4];
        codes[0] = 4'h4; codes[1] = 4'h8; codes[2] = 4'hC; codes[3] = 4'h3;
        all_ok = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(codes[i], (i == 3), ok);
            all_ok &= ok;
            if (i < 3) begin
                total++;
                if (out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL full_early_valid: digit %0d valid=%b want 0", i, out_valid);
                end
            end
        end
        total++;
        if (!all_ok || {out_valid, out_bcd, out_count, out_err} !== {1'b1, 16'h1590, 3'd4, 1'b0}) begin
            bad++;
            $display("FAIL full_frame: ok=%b valid=%b bcd=%h cnt=%0d err=%b, want 1 1590 4 0",
                     all_ok, out_valid, out_bcd, out_count, out_err);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== 16'h0) begin
            bad++;
            $display("FAIL full_one_cycle: valid=%b ready=%b bcd=%h, want 0 1 0000",
                     out_valid, in_ready, out_bcd);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_short_frame();
        bit ok1, ok2, okv;
        send(4'h6, 1'b0, ok1);
        send(4'hA, 1'b1, ok2);
        wait_valid(okv);
        total++;
        if (!(ok1 && ok2 && okv) || {out_bcd, out_count, out_err} !== {16'h0037, 3'd2, 1'b0}) begin
            bad++;
            $display("FAIL short_frame: ok=%b bcd=%h cnt=%0d err=%b, want 0037 2 0",
                     ok1 && ok2 && okv, out_bcd, out_count, out_err);
        end
        pop();
    endtask

    task automatic test_illegal();
        bit ok, okv, all_ok;
        all_ok = 1'b1;
        send(4'h4, 1'b0, ok); all_ok &= ok;
        send(4'h2, 1'b0, ok); all_ok &= ok;
        send(4'h5, 1'b1, ok); all_ok &= ok;
        wait_valid(okv);
        total++;
        if (!(all_ok && okv) || {out_bcd, out_count, out_err} !== {16'h01F2, 3'd3, 1'b1}) begin
            bad++;
            $display("FAIL illegal_frame: ok=%b bcd=%h cnt=%0d err=%b, want 01F2 3 1",
                     all_ok && okv, out_bcd, out_count, out_err);
        end
        pop();
        send(4'h3, 1'b1, ok);
        wait_valid(okv);
        total++;
        if (!(ok && okv) || {out_bcd, out_count, out_err} !== {16'h0000, 3'd1, 1'b0}) begin
            bad++;
            $display("FAIL illegal_next: ok=%b bcd=%h cnt=%0d err=%b, want 0000 1 0",
                     ok && okv, out_bcd, out_count, out_err);
        end
        pop();
    endtask

    task automatic test_backpressure();
        bit ok, okv, all_ok, frozen;
        logic [3:0] codes [4];
        codes[0] = 4'h4; codes[1] = 4'h8; codes[2] = 4'hC; codes[3] = 4'h3;
        all_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(codes[i], (i == 3), ok);
            all_ok &= ok;
        end
        wait_valid(okv);
        in_valid = 1'b1;
        in_digit = 4'h7;
        in_last  = 1'b1;
        frozen = all_ok && okv;
        for (int i = 0; i < 5; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                {out_bcd, out_count, out_err} !== {16'h1590, 3'd4, 1'b0}) frozen = 1'b0;
            @(negedge clk);
        end
        total++;
        if (!frozen) begin
            bad++;
            $display("FAIL backpressure_hold: ready=%b valid=%b bcd=%h cnt=%0d, want 0 1 1590 4",
                     in_ready, out_valid, out_bcd, out_count);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bcd !== 16'h0) begin
            bad++;
            $display("FAIL backpressure_release: ready=%b valid=%b bcd=%h, want 1 0 0000",
                     in_ready, out_valid, out_bcd);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        total++;
        if (out_valid !== 1'b1 || {out_bcd, out_count, out_err} !== {16'h0004, 3'd1, 1'b0}) begin
            bad++;
            $display("FAIL backpressure_accept: valid=%b bcd=%h cnt=%0d err=%b, want 1 0004 1 0",
                     out_valid, out_bcd, out_count, out_err);
        end
        pop();
    endtask

    task automatic test_overflow_reset();
        bit ok, all_ok, seen;
        all_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(4'(3 + i), 1'b0, ok);
            all_ok &= ok;
        end
        total++;
        if (!all_ok || {out_valid, out_bcd, out_count, out_err} !== {1'b1, 16'h0123, 3'd4, 1'b0}) begin
            bad++;
            $display("FAIL overflow_frame: ok=%b valid=%b bcd=%h cnt=%0d, want 1 0123 4",
                     all_ok, out_valid, out_bcd, out_count);
        end
        out_ready = 1'b1;
        send(4'h7, 1'b0, ok);
        out_ready = 1'b0;
        total++;
        if (!ok || {out_valid, out_bcd, out_count} !== {1'b0, 16'h0004, 3'd1}) begin
            bad++;
            $display("FAIL overflow_fifth: ok=%b valid=%b bcd=%h cnt=%0d, want 0 0004 1",
                     ok, out_valid, out_bcd, out_count);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, in_ready, out_bcd, out_count, out_err} !==
            {1'b0, 1'b1, 16'h0000, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL async_reset: valid=%b ready=%b bcd=%h cnt=%0d, want 0 1 0000 0",
                     out_valid, in_ready, out_bcd, out_count);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        out_ready = 1'b0;
        total++;
        if (seen) begin
            bad++;
            $display("FAIL reset_discard: out_valid appeared=1 after reset, want 0");
        end
    endtask

    task automatic test_random_frames();
        bit ok, okv, all_ok, stable;
        int len, code, exp_bcd, exp_cnt, dly;
        bit exp_err, last;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 4);
            exp_bcd = 0;
            exp_err = 1'b0;
            exp_cnt = len;
            all_ok = 1'b1;
            for (int i = 0; i < len; i++) begin
                code = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(3, 12);
                exp_bcd = exp_bcd * 16 + ref_digit(code);
                if (ref_digit(code) == 15) exp_err = 1'b1;
                last = (i == len - 1) ? ((len < 4) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
                send(4'(code), last, ok);
                all_ok &= ok;
            end
            wait_valid(okv);
            dly = $urandom_range(0, 3);
            stable = 1'b1;
            for (int d = 0; d < dly; d++) begin
                @(negedge clk);
                if (in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
            end
            total++;
            if (!(all_ok && okv && stable) ||
                {out_bcd, out_count, out_err} !== {16'(exp_bcd), CW'(exp_cnt), exp_err}) begin
                bad++;
                $display("FAIL random_frame %0d: ok=%b bcd=%h cnt=%0d err=%b, want %h %0d %b",
                         f, all_ok && okv && stable, out_bcd, out_count, out_err,
                         16'(exp_bcd), exp_cnt, exp_err);
            end
            pop();
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_frame();
        test_illegal();
        test_backpressure();
        test_overflow_reset();
        test_random_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
